timer_reg_if: RTL and testbench
===============================

# timer_reg_if

Bus-side register interface of the timer IP, directly downstream of the CPU bus master. Decodes 8-bit APB-style transfers (setup/access/ready), holds the timer's control, reload, status and interrupt-enable registers, and exchanges control/status with the timer counter core. Provides a programmable number of wait states and flags bad accesses with `cpu_slverr`.

## Interface
- `WAIT_CYCLES`, default 0, extra wait cycles inserted before `cpu_ready` (0..7).
- `cpu_clk  input  1  clock; all state changes on rising edge`
- `cpu_reset_n  input  1  reset; asynchronous, active-low`
- `cpu_sel  input  1  transfer select`
- `cpu_enable  input  1  access-phase indicator`
- `cpu_write  input  1  1 = write, 0 = read`
- `cpu_address  input  8  register address`
- `cpu_wdata  input  8  write data`
- `cpu_rdata  output  8  read data; valid only while cpu_ready=1, else 0x00`
- `cpu_ready  output  1  transfer complete, one-cycle pulse`
- `cpu_slverr  output  1  error; valid only with cpu_ready, else 0`
- `tmr_tcnt  input  8  current counter value from core`
- `tmr_ovf  input  1  one-cycle overflow pulse from core`
- `tmr_udf  input  1  one-cycle underflow pulse from core`
- `tmr_tdr  output  8  reload value`
- `tmr_load  output  1  one-cycle load request`
- `tmr_en  output  1  count enable`
- `tmr_dn  output  1  0 = count up, 1 = count down`
- `tmr_cks  output  2  clock-select code`
- `tmr_ovf_int  output  1  overflow interrupt`
- `tmr_udf_int  output  1  underflow interrupt`

## Operation
- Register map (undefined bits read 0, writes ignored):
  - 0x00 TDR, RW, reset 0x00.
  - 0x01 TCR, RW, reset 0x00: bit7 LOAD (write-1 pulses `tmr_load` for one cycle, always reads 0), bit5 EN, bit4 DN, bits1:0 CKS.
  - 0x02 TSR, reset 0x00: bit1 UDF, bit0 OVF; set by the matching `tmr_*` pulse; write-1-to-clear, write-0 no effect.
  - 0x03 TIE, RW, reset 0x00: bit1 UDF_IE, bit0 OVF_IE.
  - 0x04 TCNT, RO, returns `tmr_tcnt` sampled on the completing edge.
- Errors (`cpu_slverr`=1 with `cpu_ready`): address > 0x04, or write to 0x04. An errored write changes no state. An errored read returns 0x00.
- FSM states:
  - IDLE: go to SETUP on `cpu_sel & ~cpu_enable`. Any other input, including `sel&enable` with no setup, stays in IDLE with no response.
  - SETUP: on `sel&enable`, load the wait counter with `WAIT_CYCLES` and go to ACCESS. If `sel` drops, go to IDLE.
  - ACCESS: decrement the counter each edge. At zero, commit the write or capture the read, assert `cpu_ready` for the next cycle, and go to DONE. If `sel` drops, abort to IDLE with no commit.
  - DONE: `cpu_ready` high for this cycle only, then IDLE.
- Address, write flag and wdata are latched at SETUP→ACCESS. Later bus changes do not affect the transfer.
- `tmr_ovf_int = OVF & OVF_IE` and `tmr_udf_int = UDF & UDF_IE`, both registered.
- A hardware set and a W1C of the same TSR bit on the same edge: set wins, bit stays 1.
- Reset mid-transfer: all outputs and registers go to 0 immediately, FSM goes to IDLE, and no `cpu_ready` is issued for the aborted transfer.

## Timing
- Edge E1 is the first edge sampling `sel&enable`.
- With WAIT_CYCLES=0, commit happens at E1+1. `cpu_ready`, `cpu_rdata` and `cpu_slverr` are high/valid from E1+1 to E1+2. Each wait cycle adds one cycle.
- The master samples `cpu_ready` at E1+2 or later.
- All outputs are registered. Every output resets to 0.
- `tmr_load` is high for exactly the cycle after the committing edge.
- Register values appear on `tmr_tdr`/`tmr_en`/`tmr_dn`/`tmr_cks` in the cycle after commit.
- An interrupt output rises one cycle after its TSR bit sets.
- Back-to-back transfers: a new SETUP is accepted in the cycle after DONE.

## Structure
- Shared package `timer_pkg`: register address constants (ADDR_TDR..ADDR_TCNT), TCR/TSR/TIE bit positions, reset values, FSM state typedef.
- One sub-module, `timer_bus_fsm`: handles the handshake, wait counter and address latch, and emits `wr_stb`/`rd_stb`/`err` plus the latched address and data.
- The register file and interrupt logic stay in `timer_reg_if`.

## Test plan
- Reset, then read 0x00–0x04 with `tmr_tcnt`=0x5A: returns 0x00,0x00,0x00,0x00,0x5A, `slverr`=0, and `cpu_ready` rises at E1+1.
- Write TDR=0xC3, then TCR=0xB2: `tmr_tdr`=0xC3, `tmr_en`=1, `tmr_dn`=1, `tmr_cks`=2, one `tmr_load` pulse. TCR readback is 0x32.
- Set TIE=0x01 and pulse `tmr_ovf`: TSR reads 0x01 and `tmr_ovf_int`=1. Writing TSR=0x01 clears the bit and the interrupt. Writing W1C in the same cycle as a second `tmr_ovf` pulse leaves TSR=0x01.
- Write 0x04 with 0xFF, then read 0x10: both transfers complete with `slverr`=1, no register changes, and the read returns 0x00.
- WAIT_CYCLES=3: `cpu_ready` rises at E1+4. Dropping `cpu_sel` during ACCESS aborts the transfer with no write and no ready.
- Assert reset in the ACCESS cycle of a TDR=0x77 write: TDR stays 0x00, no `cpu_ready`, and the next transfer completes normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer register interface: register map, bit
// positions, reset values and the bus handshake state type.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TIE  = 8'h03;
  localparam logic [7:0] ADDR_TCNT = 8'h04;

  localparam int TCR_LOAD = 7;
  localparam int TCR_EN   = 5;
  localparam int TCR_DN   = 4;
  localparam int TCR_CKS0 = 0;

  localparam int TSR_UDF = 1;
  localparam int TSR_OVF = 0;

  localparam int TIE_UDF_IE = 1;
  localparam int TIE_OVF_IE = 0;

  // Storable bits per register; LOAD is a strobe and is never stored.
  localparam logic [7:0] TCR_MASK = 8'h33;
  localparam logic [7:0] TSR_MASK = 8'h03;
  localparam logic [7:0] TIE_MASK = 8'h03;

  localparam logic [7:0] TDR_RST = 8'h00;
  localparam logic [7:0] TCR_RST = 8'h00;
  localparam logic [7:0] TSR_RST = 8'h00;
  localparam logic [7:0] TIE_RST = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } bus_state_t;

endpackage

// File: rtl/timer_bus_fsm.sv
// Bus handshake for the timer registers: setup/access sequencing, wait-state
// down-counter, transfer latch, and commit strobes with error qualification.
//
//   state  | meaning
//   IDLE   | waiting for sel & ~enable
//   SETUP  | address phase; sel & enable starts the access
//   ACCESS | counting wait states; commits when the counter reaches zero
//   DONE   | cpu_ready cycle, then back to IDLE
module timer_bus_fsm
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sel,
  input  logic       i_enable,
  input  logic       i_write,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_wr_stb,
  output logic       o_rd_stb,
  output logic       o_err,
  output logic [7:0] o_addr,
  output logic [7:0] o_wdata
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_CYCLES);

  bus_state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic       r_write;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       w_start;
  logic       w_commit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
    end else if (w_start) begin
      r_cnt   <= WAIT_CNT;
      r_write <= i_write;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (r_state == ST_ACCESS && r_cnt != 3'd0) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_sel && !i_enable) w_next = ST_SETUP;
      ST_SETUP: begin
        if (!i_sel) w_next = ST_IDLE;
        else if (i_enable) begin
          w_start = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Losing sel during the access aborts it without a commit.
        if (!i_sel) w_next = ST_IDLE;
        else if (r_cnt == 3'd0) begin
          w_commit = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign o_wr_stb = w_commit & r_write;
  assign o_rd_stb = w_commit & ~r_write;
  assign o_err    = w_commit & ((r_addr > ADDR_TCNT) | (r_write & (r_addr == ADDR_TCNT)));
  assign o_addr   = r_addr;
  assign o_wdata  = r_wdata;

endmodule

// File: rtl/timer_reg_if.sv
// Timer register file behind the bus handshake: TDR/TCR/TSR/TIE/TCNT,
// load strobe, status capture with write-1-to-clear, and interrupts.
module timer_reg_if
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic       cpu_clk,
  input  logic       cpu_reset_n,
  input  logic       cpu_sel,
  input  logic       cpu_enable,
  input  logic       cpu_write,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic       cpu_slverr,
  input  logic [7:0] tmr_tcnt,
  input  logic       tmr_ovf,
  input  logic       tmr_udf,
  output logic [7:0] tmr_tdr,
  output logic       tmr_load,
  output logic       tmr_en,
  output logic       tmr_dn,
  output logic [1:0] tmr_cks,
  output logic       tmr_ovf_int,
  output logic       tmr_udf_int
);

  logic       w_wr_stb, w_rd_stb, w_err, w_wr_ok;
  logic [7:0] w_addr, w_wdata, w_rdval, w_w1c, w_hw_set;
  logic [7:0] r_tdr, r_tcr, r_tsr, r_tie, r_rdata;
  logic       r_ready, r_slverr, r_load, r_ovf_int, r_udf_int;

  timer_bus_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_bus_fsm (
    .i_clk    (cpu_clk),
    .i_rst_n  (cpu_reset_n),
    .i_sel    (cpu_sel),
    .i_enable (cpu_enable),
    .i_write  (cpu_write),
    .i_addr   (cpu_address),
    .i_wdata  (cpu_wdata),
    .o_wr_stb (w_wr_stb),
    .o_rd_stb (w_rd_stb),
    .o_err    (w_err),
    .o_addr   (w_addr),
    .o_wdata  (w_wdata)
  );

  assign w_wr_ok = w_wr_stb & ~w_err;

  always_comb begin
    w_rdval = 8'h00;
    case (w_addr)
      ADDR_TDR:  w_rdval = r_tdr;
      ADDR_TCR:  w_rdval = r_tcr;
      ADDR_TSR:  w_rdval = r_tsr;
      ADDR_TIE:  w_rdval = r_tie;
      ADDR_TCNT: w_rdval = tmr_tcnt;
      default:   w_rdval = 8'h00;
    endcase
  end

  always_comb begin
    w_hw_set          = 8'h00;
    w_hw_set[TSR_OVF] = tmr_ovf;
    w_hw_set[TSR_UDF] = tmr_udf;
    w_w1c             = (w_wr_ok && w_addr == ADDR_TSR) ? (w_wdata & TSR_MASK) : 8'h00;
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      r_tdr     <= TDR_RST;
      r_tcr     <= TCR_RST;
      r_tsr     <= TSR_RST;
      r_tie     <= TIE_RST;
      r_rdata   <= 8'h00;
      r_ready   <= 1'b0;
      r_slverr  <= 1'b0;
      r_load    <= 1'b0;
      r_ovf_int <= 1'b0;
      r_udf_int <= 1'b0;
    end else begin
      r_ready  <= w_wr_stb | w_rd_stb;
      r_slverr <= w_err;
      r_rdata  <= (w_rd_stb && !w_err) ? w_rdval : 8'h00;
      r_load   <= w_wr_ok && (w_addr == ADDR_TCR) && w_wdata[TCR_LOAD];
      if (w_wr_ok && w_addr == ADDR_TDR) r_tdr <= w_wdata;
      if (w_wr_ok && w_addr == ADDR_TCR) r_tcr <= w_wdata & TCR_MASK;
      if (w_wr_ok && w_addr == ADDR_TIE) r_tie <= w_wdata & TIE_MASK;
      // Hardware set is OR-ed after the clear so it wins on a collision.
      r_tsr     <= (r_tsr & ~w_w1c) | w_hw_set;
      r_ovf_int <= r_tsr[TSR_OVF] & r_tie[TIE_OVF_IE];
      r_udf_int <= r_tsr[TSR_UDF] & r_tie[TIE_UDF_IE];
    end
  end

  assign cpu_rdata   = r_rdata;
  assign cpu_ready   = r_ready;
  assign cpu_slverr  = r_slverr;
  assign tmr_tdr     = r_tdr;
  assign tmr_load    = r_load;
  assign tmr_en      = r_tcr[TCR_EN];
  assign tmr_dn      = r_tcr[TCR_DN];
  assign tmr_cks     = r_tcr[TCR_CKS0 +: 2];
  assign tmr_ovf_int = r_ovf_int;
  assign tmr_udf_int = r_udf_int;

endmodule

// File: tb/tb_timer_reg_if.sv
// Directed bench for timer_reg_if: one instance with no wait states and one
// with three, sharing the bus wires but selected separately.
module tb_timer_reg_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_sel = 1'b0, bus_en = 1'b0, bus_wr = 1'b0, tgt = 1'b0;
  logic [7:0] bus_addr = 8'h00, bus_wdata = 8'h00, tcnt = 8'h5A;
  logic       ovf = 1'b0, udf = 1'b0;
  logic       sel0, sel3;

  logic [7:0] rdata0, rdata3, tdr0, tdr3;
  logic       rdy0, rdy3, err0, err3, ld0, ld3, en0, en3, dn0, dn3;
  logic [1:0] cks0, cks3;
  logic       oi0, oi3, ui0, ui3;
  logic       m_rdy, m_err;
  logic [7:0] m_rdata;

  int n_chk = 0, n_fail = 0;
  int rc0 = 0, rc3 = 0, lc0 = 0;

  assign sel0    = bus_sel & ~tgt;
  assign sel3    = bus_sel & tgt;
  assign m_rdy   = tgt ? rdy3 : rdy0;
  assign m_err   = tgt ? err3 : err0;
  assign m_rdata = tgt ? rdata3 : rdata0;

  always #5 clk = ~clk;

  timer_reg_if #(.WAIT_CYCLES(0)) dut0 (
    .cpu_clk(clk), .cpu_reset_n(rst_n), .cpu_sel(sel0), .cpu_enable(bus_en),
    .cpu_write(bus_wr), .cpu_address(bus_addr), .cpu_wdata(bus_wdata),
    .cpu_rdata(rdata0), .cpu_ready(rdy0), .cpu_slverr(err0),
    .tmr_tcnt(tcnt), .tmr_ovf(ovf), .tmr_udf(udf),
    .tmr_tdr(tdr0), .tmr_load(ld0), .tmr_en(en0), .tmr_dn(dn0), .tmr_cks(cks0),
    .tmr_ovf_int(oi0), .tmr_udf_int(ui0));

  timer_reg_if #(.WAIT_CYCLES(3)) dut3 (
    .cpu_clk(clk), .cpu_reset_n(rst_n), .cpu_sel(sel3), .cpu_enable(bus_en),
    .cpu_write(bus_wr), .cpu_address(bus_addr), .cpu_wdata(bus_wdata),
    .cpu_rdata(rdata3), .cpu_ready(rdy3), .cpu_slverr(err3),
    .tmr_tcnt(tcnt), .tmr_ovf(ovf), .tmr_udf(udf),
    .tmr_tdr(tdr3), .tmr_load(ld3), .tmr_en(en3), .tmr_dn(dn3), .tmr_cks(cks3),
    .tmr_ovf_int(oi3), .tmr_udf_int(ui3));

  always @(negedge clk) begin
    if (rdy0) rc0++;
    if (rdy3) rc3++;
    if (ld0)  lc0++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; drives setup immediately so back-to-back
  // calls start a new SETUP in the cycle after DONE.
  task automatic xfer(input logic which, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input logic ovf_at_commit,
                      output logic [7:0] rd, output logic er, output int lat);
    tgt = which; bus_sel = 1'b1; bus_en = 1'b0; bus_wr = wr;
    bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_en = 1'b1;
    @(posedge clk); #1;                  // E1
    check("ready_low_at_e1", {31'd0, m_rdy}, 32'd0);
    bus_addr = ~a; bus_wdata = ~d; bus_wr = ~wr;
    if (ovf_at_commit) ovf = 1'b1;
    lat = 0; rd = 8'h00; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      ovf = 1'b0;
      lat++;
      if (m_rdy) break;
    end
    if (!m_rdy) check("ready_timeout", 32'd0, 32'd1);
    rd = m_rdata; er = m_err;
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, m_rdy}, 32'd0);
    check("rdata_idle_zero", {24'd0, m_rdata}, 32'd0);
    bus_sel = 1'b0; bus_en = 1'b0;
  endtask

  logic [7:0] rd;
  logic       er;
  int         lat, rcs, lcs;
  logic [7:0] rd_exp [5];

  initial begin
    rd_exp[0] = 8'h00; rd_exp[1] = 8'h00; rd_exp[2] = 8'h00;
    rd_exp[3] = 8'h00; rd_exp[4] = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", {24'd0, rdata0}, 32'd0);
    check("rst_ready", {31'd0, rdy0}, 32'd0);
    check("rst_slverr", {31'd0, err0}, 32'd0);
    check("rst_outs", {tdr0, ld0, en0, dn0, cks0, oi0, ui0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, 1'b0, 8'(i), 8'h00, 1'b0, rd, er, lat);
      check($sformatf("rd_reset_%0d", i), {24'd0, rd}, {24'd0, rd_exp[i]});
      check($sformatf("rd_err_%0d", i), {31'd0, er}, 32'd0);
      check($sformatf("rd_lat_%0d", i), lat, 32'd1);
    end

    xfer(1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, rd, er, lat);
    check("tdr_out", {24'd0, tdr0}, 32'hC3);
    check("tdr_wr_err", {31'd0, er}, 32'd0);
    lcs = lc0;
    xfer(1'b0, 1'b1, 8'h01, 8'hB2, 1'b0, rd, er, lat);
    check("load_pulses", lc0 - lcs, 32'd1);
    check("tcr_en_dn_cks", {29'd0, en0, dn0, cks0}, 32'b1110);
    xfer(1'b0, 1'b0, 8'h01, 8'h00, 1'b0, rd, er, lat);
    check("tcr_readback", {24'd0, rd}, 32'h32);
    check("tcr_read_no_load", lc0 - lcs, 32'd1);

    xfer(1'b0, 1'b1, 8'h03, 8'h01, 1'b0, rd, er, lat);
    ovf = 1'b1; @(posedge clk); #1; ovf = 1'b0;
    @(posedge clk); #1;
    check("ovf_int_set", {30'd0, oi0, ui0}, 32'b10);
    xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0, rd, er, lat);
    check("tsr_ovf", {24'd0, rd}, 32'h01);
    xfer(1'b0, 1'b1, 8'h02, 8'h01, 1'b0, rd, er, lat);
    check("ovf_int_clr", {31'd0, oi0}, 32'd0);
    xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0, rd, er, lat);
    check("tsr_cleared", {24'd0, rd}, 32'h00);
    xfer(1'b0, 1'b1, 8'h02, 8'h01, 1'b1, rd, er, lat);
    check("set_wins_int", {31'd0, oi0}, 32'd1);
    xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0, rd, er, lat);
    check("set_wins_tsr", {24'd0, rd}, 32'h01);
    udf = 1'b1; @(posedge clk); #1; udf = 1'b0;
    @(posedge clk); #1;
    check("udf_int_masked", {30'd0, oi0, ui0}, 32'b10);
    xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0, rd, er, lat);
    check("tsr_both", {24'd0, rd}, 32'h03);

    xfer(1'b0, 1'b1, 8'h04, 8'hFF, 1'b0, rd, er, lat);
    check("wr_tcnt_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, rd, er, lat);
    check("rd_bad_err", {31'd0, er}, 32'd1);
    check("rd_bad_data", {24'd0, rd}, 32'h00);
    xfer(1'b0, 1'b1, 8'h05, 8'h00, 1'b0, rd, er, lat);
    check("wr_bad_err", {31'd0, er}, 32'd1);
    check("err_no_change", {tdr0, 2'b00, en0, dn0, cks0, 2'b00}, {16'd0, 8'hC3, 8'b0011_1000});
    xfer(1'b0, 1'b0, 8'h04, 8'h00, 1'b0, rd, er, lat);
    check("tcnt_read", {24'd0, rd}, 32'h5A);
    check("tcnt_read_err", {31'd0, er}, 32'd0);

    // sel & enable with no setup phase must be ignored.
    rcs = rc0;
    tgt = 1'b0; bus_sel = 1'b1; bus_en = 1'b1; bus_wr = 1'b1;
    bus_addr = 8'h00; bus_wdata = 8'hEE;
    repeat (4) @(posedge clk);
    #1; bus_sel = 1'b0; bus_en = 1'b0;
    check("nosetup_no_ready", rc0 - rcs, 32'd0);
    check("nosetup_tdr", {24'd0, tdr0}, 32'hC3);

    xfer(1'b1, 1'b1, 8'h00, 8'h3C, 1'b0, rd, er, lat);
    check("w3_wr_lat", lat, 32'd4);
    xfer(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, rd, er, lat);
    check("w3_rd_lat", lat, 32'd4);
    check("w3_rd_data", {24'd0, rd}, 32'h3C);

    rcs = rc3;
    tgt = 1'b1; bus_sel = 1'b1; bus_en = 1'b0; bus_wr = 1'b1;
    bus_addr = 8'h00; bus_wdata = 8'h99;
    @(posedge clk); #1; bus_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; bus_sel = 1'b0; bus_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_ready", rc3 - rcs, 32'd0);
    check("abort_no_write", {24'd0, tdr3}, 32'h3C);

    rcs = rc3;
    tgt = 1'b1; bus_sel = 1'b1; bus_en = 1'b0; bus_wr = 1'b1;
    bus_addr = 8'h00; bus_wdata = 8'h77;
    @(posedge clk); #1; bus_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_tdr", {24'd0, tdr3}, 32'h00);
    check("rst_async_tdr0", {24'd0, tdr0}, 32'h00);
    repeat (2) @(posedge clk);
    #1; bus_sel = 1'b0; bus_en = 1'b0;
    #3; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_ready", rc3 - rcs, 32'd0);
    check("rst_tdr_zero", {24'd0, tdr3}, 32'h00);
    xfer(1'b1, 1'b1, 8'h00, 8'h12, 1'b0, rd, er, lat);
    check("post_rst_lat", lat, 32'd4);
    xfer(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, rd, er, lat);
    check("post_rst_read", {24'd0, rd}, 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
